rmii_frame_gen: RTL and testbench
=================================

RMII_FRAME_GEN -- requirements
Module: rmii_frame_gen

Interface
- REQ-001: Parameter DST_MAC, default 48'hFF_FF_FF_FF_FF_FF, destination address; byte [47:40] is sent first.
- REQ-002: Parameter SRC_MAC, default 48'h12_34_56_78_9A_BC, source address; byte [47:40] is sent first.
- REQ-003: Parameter IPG_CYCLES, default 48, minimum idle cycles after each frame (12 bytes).
- REQ-004: clk  input  1  single clock, 50 MHz RMII reference; one dibit per cycle; all logic on rising edge.
- REQ-005: rst  input  1  reset, asynchronous, active-high.
- REQ-006: data  input  16  payload word, latched on accepted start.
- REQ-007: ethertype  input  16  EtherType, latched on accepted start.
- REQ-008: start  input  1  frame request, sampled each cycle.
- REQ-009: crsdv  output  1  carrier/data valid toward the MAC receiver.
- REQ-010: rxd  output  2  dibit toward the MAC receiver.
- REQ-011: busy  output  1  high from accepted start through the end of IPG.
- REQ-012: done  output  1  one-cycle pulse when a frame has been fully sent.

Function
- REQ-013: States are IDLE, PREAMBLE, HEADER, PAYLOAD, FCS and IPG.
- REQ-014: start is accepted only in IDLE; start while busy is ignored and not queued.
- REQ-015: On an accepted start at edge N, the block latches data and ethertype, asserts busy, and drives the first dibit with crsdv=1 after edge N+1.
- REQ-016: PREAMBLE sends 7 bytes of 0x55 followed by SFD 0xD5 (32 cycles).
- REQ-017: HEADER sends DST_MAC, SRC_MAC, then ethertype MSB byte first (14 bytes, 56 cycles).
- REQ-018: PAYLOAD sends data[15:8], data[7:0], then 44 bytes of 0x00 (46 bytes, 184 cycles).
- REQ-019: Every byte is sent LSB dibit first: rxd = byte[1:0], [3:2], [5:4], [7:6] on consecutive cycles.
- REQ-020: The FCS is Ethernet CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) over the HEADER and PAYLOAD bytes only, updated 2 bits per cycle.
- REQ-021: The FCS state sends the complement of the CRC register as 4 bytes, register bit 0 first, over 16 cycles.
- REQ-022: crsdv stays high for exactly 288 consecutive cycles per frame, with no gaps.
- REQ-023: rxd = 2'b00 whenever crsdv = 0.
- REQ-024: The CRC register is reinitialised to 0xFFFFFFFF on every accepted start.
- REQ-025: done pulses for one cycle in the first IPG cycle.
- REQ-026: IPG holds crsdv=0 for IPG_CYCLES cycles, then returns to IDLE and deasserts busy.
- REQ-027: Back-to-back operation: a start held high continuously yields frames whose crsdv rising edges are exactly 288+IPG_CYCLES+1 cycles apart.
- REQ-028: Changes on data or ethertype after the accepted start do not affect the frame in flight.

Reset
- REQ-029: While rst=1, asynchronously: crsdv=0, rxd=0, busy=0, done=0, state=IDLE, CRC=0xFFFFFFFF.
- REQ-030: Reset mid-frame truncates the frame immediately; the first start accepted after release begins a fresh preamble.
- REQ-031: A start coincident with rst=1 is ignored.

Verification
- REQ-032: Release rst, pulse start once with ethertype=0x0800, data=0x1234 -> the first 28 dibits are 01, then 01,01,01,11; crsdv is high for exactly 288 cycles; done pulses once.
- REQ-033: Same frame, bench assembles bytes from the dibits -> bytes 8-13 are FF, bytes 14-19 are 12 34 56 78 9A BC, bytes 20-23 are 08 00 12 34, bytes 24-67 are 00.
- REQ-034: CRC-32 (init 0xFFFFFFFF, reflected) over bytes 8-71 including the FCS -> register residue equals 0xDEBB20E3; a bench reference CRC also matches the FCS for data=0x0000..0x007F.
- REQ-035: Hold start=1 for 3 frames -> crsdv rising edges are 337 cycles apart (default IPG), and no start is accepted while busy.
- REQ-036: Assert rst at cycle 100 of a frame -> crsdv, rxd and busy are 0 within the same cycle; a new start then yields a full, correct 288-cycle frame.
- REQ-037: Change data at cycle 60 of a frame -> the payload bytes still carry the value latched at start.

Source files
------------

// File: rtl/rmii_frame_gen.sv
// RMII receive-side frame generator: preamble, fixed MAC header, 46-byte payload, CRC-32 FCS, then IPG.
// First dibit appears one cycle after an accepted start; start is ignored (not queued) while busy.
module rmii_frame_gen #(
    parameter logic [47:0] DST_MAC    = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC    = 48'h12_34_56_78_9A_BC,
    parameter int          IPG_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    input  logic [15:0] ethertype,
    input  logic        start,
    output logic        crsdv,
    output logic [1:0]  rxd,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, FCS, IPG} state_t;

    localparam logic [15:0] IPG_LAST = 16'(IPG_CYCLES - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [15:0] data_q;
    logic [15:0] eth_q;
    logic [31:0] crc_q;
    logic        crsdv_q;
    logic [1:0]  rxd_q;
    logic        busy_q;
    logic        done_q;

    logic [7:0]  byte_d;
    logic [1:0]  dibit_d;
    logic [31:0] crc_d;
    logic [31:0] fcs_d;
    logic        last_d;
    logic        tx_d;

    // Reflected CRC-32, two serial bits per call, rxd[0] consumed first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        byte_d = 8'h00;
        last_d = 1'b0;
        case (state_q)
            PREAMBLE: begin
                byte_d = (cnt_q[4:2] == 3'd7) ? 8'hD5 : 8'h55;
                last_d = (cnt_q == 16'd31);
            end
            HEADER: begin
                case (cnt_q[5:2])
                    4'd0:    byte_d = DST_MAC[47:40];
                    4'd1:    byte_d = DST_MAC[39:32];
                    4'd2:    byte_d = DST_MAC[31:24];
                    4'd3:    byte_d = DST_MAC[23:16];
                    4'd4:    byte_d = DST_MAC[15:8];
                    4'd5:    byte_d = DST_MAC[7:0];
                    4'd6:    byte_d = SRC_MAC[47:40];
                    4'd7:    byte_d = SRC_MAC[39:32];
                    4'd8:    byte_d = SRC_MAC[31:24];
                    4'd9:    byte_d = SRC_MAC[23:16];
                    4'd10:   byte_d = SRC_MAC[15:8];
                    4'd11:   byte_d = SRC_MAC[7:0];
                    4'd12:   byte_d = eth_q[15:8];
                    4'd13:   byte_d = eth_q[7:0];
                    default: byte_d = 8'h00;
                endcase
                last_d = (cnt_q == 16'd55);
            end
            PAYLOAD: begin
                case (cnt_q[7:2])
                    6'd0:    byte_d = data_q[15:8];
                    6'd1:    byte_d = data_q[7:0];
                    default: byte_d = 8'h00;
                endcase
                last_d = (cnt_q == 16'd183);
            end
            FCS:     last_d = (cnt_q == 16'd15);
            IPG:     last_d = (cnt_q == IPG_LAST);
            default: last_d = 1'b0;
        endcase

        fcs_d   = ~crc_q;
        dibit_d = (state_q == FCS) ? fcs_d[{cnt_q[3:0], 1'b0} +: 2]
                                   : byte_d[{cnt_q[1:0], 1'b0} +: 2];
        tx_d    = (state_q == PREAMBLE) || (state_q == HEADER) ||
                  (state_q == PAYLOAD)  || (state_q == FCS);
        crc_d   = ((state_q == HEADER) || (state_q == PAYLOAD)) ? crc_dibit(crc_q, dibit_d) : crc_q;
    end

    // Outputs are registered from the current state, so the wire lags the state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            eth_q   <= '0;
            crc_q   <= 32'hFFFF_FFFF;
            crsdv_q <= 1'b0;
            rxd_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            crsdv_q <= tx_d;
            rxd_q   <= tx_d ? dibit_d : 2'b00;
            crc_q   <= crc_d;
            cnt_q   <= last_d ? 16'd0 : cnt_q + 16'd1;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        data_q  <= data;
                        eth_q   <= ethertype;
                        crc_q   <= 32'hFFFF_FFFF;
                        busy_q  <= 1'b1;
                        state_q <= PREAMBLE;
                    end
                end
                PREAMBLE: if (last_d) state_q <= HEADER;
                HEADER:   if (last_d) state_q <= PAYLOAD;
                PAYLOAD:  if (last_d) state_q <= FCS;
                FCS:      if (last_d) state_q <= IPG;
                IPG: begin
                    done_q <= (cnt_q == 16'd0);
                    if (last_d) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign crsdv = crsdv_q;
    assign rxd   = rxd_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_rmii_frame_gen.sv
// Directed bench for rmii_frame_gen: byte tables, CRC residue, back-to-back spacing, reset and latch corners.
module tb_rmii_frame_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] data;
    logic [15:0] ethertype;
    logic        crsdv;
    logic [1:0]  rxd;
    logic        busy;
    logic        done;

    always #10 clk = ~clk;

    rmii_frame_gen dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .ethertype (ethertype),
        .start     (start),
        .crsdv     (crsdv),
        .rxd       (rxd),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int         idx;
        logic [7:0] exp;
    } bvec_t;

    typedef struct {
        logic [15:0] d;
        logic [15:0] e;
        logic [31:0] tail;
    } fvec_t;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] dib [0:511];
    int         cap_len;
    int         cap_dones;
    int         rxd_bad = 0;
    bit         cap_to;
    bvec_t      btbl [0:16];
    fvec_t      ftbl [0:3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input int k);
        return {dib[4*k+3], dib[4*k+2], dib[4*k+1], dib[4*k]};
    endfunction

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] residue();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int k = 8; k < 72; k++) c = crc_upd(c, fbyte(k));
        return c;
    endfunction

    function automatic logic [31:0] ref_fcs();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int k = 8; k < 68; k++) c = crc_upd(c, fbyte(k));
        return ~c;
    endfunction

    function automatic logic [31:0] got_fcs();
        return {fbyte(71), fbyte(70), fbyte(69), fbyte(68)};
    endfunction

    function automatic logic [31:0] got_tail();
        return {fbyte(20), fbyte(21), fbyte(22), fbyte(23)};
    endfunction

    // Waits for crsdv, records dibits while it is high, then watches 10 more cycles for done.
    task automatic capture();
        int w;
        w         = 0;
        cap_len   = 0;
        cap_dones = 0;
        cap_to    = 1'b0;
        while (!crsdv && w < 400) begin
            if (done) cap_dones++;
            if (rxd != 2'b00) rxd_bad++;
            @(negedge clk);
            w++;
        end
        if (!crsdv) begin
            cap_to = 1'b1;
            return;
        end
        while (crsdv && cap_len < 512) begin
            dib[cap_len] = rxd;
            cap_len++;
            if (done) cap_dones++;
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            if (done) cap_dones++;
            if (!crsdv && rxd != 2'b00) rxd_bad++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && w < 800) begin
            @(negedge clk);
            w++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic run_one(input logic [15:0] d, input logic [15:0] e);
        data      = d;
        ethertype = e;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        capture();
        wait_idle();
    endtask

    initial begin
        int bad;
        int nr;
        int cyc;
        int rises [0:2];
        logic prev;

        btbl[0]  = '{0,  8'h55};  btbl[1]  = '{6,  8'h55};  btbl[2]  = '{7,  8'hD5};
        btbl[3]  = '{8,  8'hFF};  btbl[4]  = '{13, 8'hFF};  btbl[5]  = '{14, 8'h12};
        btbl[6]  = '{15, 8'h34};  btbl[7]  = '{16, 8'h56};  btbl[8]  = '{17, 8'h78};
        btbl[9]  = '{18, 8'h9A};  btbl[10] = '{19, 8'hBC};  btbl[11] = '{20, 8'h08};
        btbl[12] = '{21, 8'h00};  btbl[13] = '{22, 8'h12};  btbl[14] = '{23, 8'h34};
        btbl[15] = '{24, 8'h00};  btbl[16] = '{67, 8'h00};

        ftbl[0] = '{16'h1234, 16'h0800, 32'h0800_1234};
        ftbl[1] = '{16'hABCD, 16'h86DD, 32'h86DD_ABCD};
        ftbl[2] = '{16'h0000, 16'hFFFF, 32'hFFFF_0000};
        ftbl[3] = '{16'hFFFF, 16'h0000, 32'h0000_FFFF};

        rst = 1'b1; start = 1'b0; data = '0; ethertype = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {crsdv, rxd, busy, done}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reference frame, with explicit accept latency and byte-level checks.
        data = 16'h1234; ethertype = 16'h0800; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("accept_latency", {busy, crsdv}, 2'b10);
        capture();
        check("frame_seen", cap_to, 0);
        check("crsdv_len", cap_len, 288);
        check("done_pulses", cap_dones, 1);
        bad = 0;
        for (int i = 0; i < 28; i++) if (dib[i] != 2'b01) bad++;
        check("preamble_dibits", bad, 0);
        check("sfd_dibits", {dib[28], dib[29], dib[30], dib[31]}, 8'b01_01_01_11);
        for (int i = 0; i < 17; i++)
            check($sformatf("byte_%0d", btbl[i].idx), fbyte(btbl[i].idx), btbl[i].exp);
        bad = 0;
        for (int k = 24; k < 68; k++) if (fbyte(k) != 8'h00) bad++;
        check("pad_zero_bytes", bad, 0);
        check("crc_residue", residue(), 32'hDEBB20E3);
        check("fcs_ref", got_fcs(), ref_fcs());
        wait_idle();

        for (int t = 0; t < 4; t++) begin
            run_one(ftbl[t].d, ftbl[t].e);
            check($sformatf("tbl%0d_len", t), cap_len, 288);
            check($sformatf("tbl%0d_done", t), cap_dones, 1);
            check($sformatf("tbl%0d_tail", t), got_tail(), ftbl[t].tail);
            check($sformatf("tbl%0d_residue", t), residue(), 32'hDEBB20E3);
        end

        for (int v = 0; v < 128; v++) begin
            run_one(16'(v), 16'h0800);
            check($sformatf("sweep_fcs_%0h", v), got_fcs(), ref_fcs());
        end

        // Inputs change and a stray start arrive mid-frame; neither may affect this frame.
        data = 16'hABCD; ethertype = 16'h88B5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fork
            capture();
            begin
                repeat (61) @(negedge clk);
                data = 16'h5555; ethertype = 16'h1111; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check("latch_len", cap_len, 288);
        check("latch_tail", got_tail(), 32'h88B5_ABCD);
        check("latch_residue", residue(), 32'hDEBB20E3);
        wait_idle();
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy || crsdv) bad++;
            @(negedge clk);
        end
        check("busy_start_not_queued", bad, 0);

        // Start held high: rising edges of crsdv must be 337 cycles apart.
        data = 16'h0042; ethertype = 16'h0800; start = 1'b1;
        nr = 0; cyc = 0; prev = crsdv;
        rises[0] = 0; rises[1] = 0; rises[2] = 0;
        while (nr < 3 && cyc < 1500) begin
            @(negedge clk);
            cyc++;
            if (crsdv && !prev) begin
                rises[nr] = cyc;
                nr++;
            end
            prev = crsdv;
        end
        start = 1'b0;
        check("b2b_frames", nr, 3);
        check("b2b_gap_1", rises[1] - rises[0], 337);
        check("b2b_gap_2", rises[2] - rises[1], 337);
        wait_idle();

        // Reset 100 cycles into a frame, with start held during reset.
        data = 16'hCAFE; ethertype = 16'h0800; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!crsdv && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        repeat (100) @(negedge clk);
        check("pre_reset_active", {busy, crsdv}, 2'b11);
        rst = 1'b1;
        #1;
        check("reset_mid_frame", {crsdv, rxd, busy, done}, 0);
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("start_during_reset", {busy, crsdv}, 0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || crsdv) bad++;
        end
        check("no_frame_after_reset", bad, 0);
        run_one(16'h0BAD, 16'h0800);
        check("post_reset_len", cap_len, 288);
        check("post_reset_sfd", fbyte(7), 8'hD5);
        check("post_reset_tail", got_tail(), 32'h0800_0BAD);
        check("post_reset_residue", residue(), 32'hDEBB20E3);

        check("rxd_zero_when_idle", rxd_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
